// File: rtl/data_checker_pkg.sv
// Shared definitions for the read-path data checker: pattern codes, FSM
// encoding and pattern seeds.
package data_check_pkg;

    typedef enum logic [1:0] {
        PAT_BYTE_CNT = 2'd0,
        PAT_WORD_CNT = 2'd1,
        PAT_WALK_ONE = 2'd2
    } pattern_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Byte-counter seed is built per lane (lane i holds i); these are whole-word seeds.
    localparam logic [31:0] SEED_BYTE_CNT_32 = 32'h0302_0100;
    localparam logic [31:0] SEED_WORD_CNT    = 32'h0000_0000;
    localparam logic [31:0] SEED_WALK_ONE    = 32'h0000_0001;

    function automatic logic pattern_ok(input logic [31:0] code);
        return code <= 32'd2;
    endfunction

endpackage

// File: rtl/data_checker_if.sv
// Received word stream from the read FIFO into the checker.
interface data_checker_if #(
    parameter int unsigned DATA_W = 32
);
    logic              data_valid;
    logic [DATA_W-1:0] datain;

    modport master (output data_valid, output datain);
    modport slave  (input  data_valid, input  datain);
endinterface

// File: rtl/data_checker_expected_gen.sv
// Expected-word generator: loads a pattern seed and steps it on each advance.
module expected_gen
    import data_check_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  pattern_e          pattern_sel,
    input  logic              advance,
    output logic [DATA_W-1:0] expected
);
    localparam int unsigned LANES = DATA_W / 8;

    pattern_e          pattern_q, pattern_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic [DATA_W-1:0] byte_seed, byte_next;

    always_comb begin
        byte_seed = '0;
        byte_next = '0;
        // Each lane steps independently by the lane count, wrapping mod 256.
        for (int unsigned i = 0; i < LANES; i++) begin
            byte_seed[8*i +: 8] = 8'(i);
            byte_next[8*i +: 8] = expected_q[8*i +: 8] + 8'(LANES);
        end
    end

    always_comb begin
        pattern_d  = pattern_q;
        expected_d = expected_q;
        if (load) begin
            pattern_d = pattern_sel;
            case (pattern_sel)
                PAT_BYTE_CNT: expected_d = byte_seed;
                PAT_WORD_CNT: expected_d = DATA_W'(SEED_WORD_CNT);
                PAT_WALK_ONE: expected_d = DATA_W'(SEED_WALK_ONE);
                default:      expected_d = '0;
            endcase
        end else if (advance) begin
            case (pattern_q)
                PAT_BYTE_CNT: expected_d = byte_next;
                PAT_WORD_CNT: expected_d = expected_q + DATA_W'(1);
                PAT_WALK_ONE: expected_d = {expected_q[DATA_W-2:0], expected_q[DATA_W-1]};
                default:      expected_d = expected_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pattern_q  <= PAT_BYTE_CNT;
            expected_q <= '0;
        end else begin
            pattern_q  <= pattern_d;
            expected_q <= expected_d;
        end
    end

    assign expected = expected_q;

endmodule

// File: rtl/data_checker.sv
// Read-path data checker: compares a received word stream against a
// deterministic pattern, counting words/mismatches and capturing the first error.
module data_checker
    import data_check_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pattern,
    input  logic              start,
    input  logic [CNT_W-1:0]  word_total,
    data_checker_if.slave     rx,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              bad_pattern,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  error_count,
    output logic [CNT_W-1:0]  first_err_index,
    output logic [DATA_W-1:0] first_err_expected,
    output logic [DATA_W-1:0] first_err_received
);
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [CNT_W-1:0]  error_count_q, error_count_d;
    logic [CNT_W-1:0]  first_err_index_q, first_err_index_d;
    logic [DATA_W-1:0] first_err_expected_q, first_err_expected_d;
    logic [DATA_W-1:0] first_err_received_q, first_err_received_d;
    logic              pass_q, pass_d;
    logic              bad_pattern_q, bad_pattern_d;

    logic              start_ok, pat_ok, gen_load, consume;
    logic [DATA_W-1:0] expected;

    assign start_ok = start && (state_q != ST_CHECK);
    assign pat_ok   = pattern_ok(pattern);
    assign gen_load = start_ok && pat_ok;
    assign consume  = (state_q == ST_CHECK) && rx.data_valid;

    expected_gen #(
        .DATA_W (DATA_W)
    ) u_expected_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (gen_load),
        .pattern_sel (pattern_e'(pattern[1:0])),
        .advance     (consume),
        .expected    (expected)
    );

    always_comb begin
        state_d              = state_q;
        total_d              = total_q;
        word_count_d         = word_count_q;
        error_count_d        = error_count_q;
        first_err_index_d    = first_err_index_q;
        first_err_expected_d = first_err_expected_q;
        first_err_received_d = first_err_received_q;
        pass_d               = pass_q;
        bad_pattern_d        = bad_pattern_q;

        if (start_ok) begin
            total_d              = word_total;
            word_count_d         = '0;
            error_count_d        = '0;
            first_err_index_d    = '0;
            first_err_expected_d = '0;
            first_err_received_d = '0;
            bad_pattern_d        = !pat_ok;
            pass_d               = 1'b0;
            if (!pat_ok) begin
                state_d = ST_DONE;
            end else if (word_total == '0) begin
                state_d = ST_DONE;
                pass_d  = 1'b1;
            end else begin
                state_d = ST_CHECK;
            end
        end else if (consume) begin
            word_count_d = word_count_q + CNT_W'(1);
            if (rx.datain != expected) begin
                if (error_count_q == '0) begin
                    first_err_index_d    = word_count_q;
                    first_err_expected_d = expected;
                    first_err_received_d = rx.datain;
                end
                if (error_count_q != '1)
                    error_count_d = error_count_q + CNT_W'(1);
            end
            // pass uses the post-increment error count so the last word counts.
            if (word_count_d == total_q) begin
                state_d = ST_DONE;
                pass_d  = (error_count_d == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q              <= ST_IDLE;
            total_q              <= '0;
            word_count_q         <= '0;
            error_count_q        <= '0;
            first_err_index_q    <= '0;
            first_err_expected_q <= '0;
            first_err_received_q <= '0;
            pass_q               <= 1'b0;
            bad_pattern_q        <= 1'b0;
        end else begin
            state_q              <= state_d;
            total_q              <= total_d;
            word_count_q         <= word_count_d;
            error_count_q        <= error_count_d;
            first_err_index_q    <= first_err_index_d;
            first_err_expected_q <= first_err_expected_d;
            first_err_received_q <= first_err_received_d;
            pass_q               <= pass_d;
            bad_pattern_q        <= bad_pattern_d;
        end
    end

    assign busy               = (state_q == ST_CHECK);
    assign done               = (state_q == ST_DONE);
    assign pass               = pass_q;
    assign bad_pattern        = bad_pattern_q;
    assign word_count         = word_count_q;
    assign error_count        = error_count_q;
    assign first_err_index    = first_err_index_q;
    assign first_err_expected = first_err_expected_q;
    assign first_err_received = first_err_received_q;

endmodule
